// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end: fetch FSM
// encoding, opcode slice positions and the prefetch-queue entry layout.
package ifetch_queue_pkg;

    localparam int ENTRY_PC_W    = 16;
    localparam int ENTRY_INSTR_W = 16;
    localparam int OPC_W         = 4;
    localparam int OPC_MSB       = ENTRY_INSTR_W - 1;
    localparam int OPC_LSB       = ENTRY_INSTR_W - OPC_W;

    // S_WAIT keeps the returning word, S_DROP discards it after a redirect.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// DEPTH-entry register FIFO with synchronous flush; the head entry is
// presented combinationally so decode sees it in the cycle it becomes valid.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would chain updates in order.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; a slot is only read after it has
    // been written, and leaving it unreset keeps it plain flops without reset.
    always_ff @(posedge Clock) begin
        if (push && !flush) mem[wr_ptr_q] <= push_data;
    end

    assign head_data = mem[rd_ptr_q];
    assign count     = count_q;

    a_no_overflow: assert property (@(posedge Clock) disable iff (!Reset_n)
        !(push && !pop && !flush && count_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge Clock) disable iff (!Reset_n)
        !(pop && !flush && count_q == '0));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one instruction-memory
// read in flight and buffers returned words in a prefetch queue for decode.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = ENTRY_PC_W,
    parameter int              INSTR_W  = ENTRY_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [OPC_W-1:0]   if_opcode,
    input  logic               id_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q;
    fetch_state_t    state_next;
    logic [PC_W-1:0] fetch_pc_q;
    logic [PC_W-1:0] issue_pc_q;
    logic [CW-1:0]   count;
    logic            issue_ok;
    logic            accept;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // ---- state register ------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_next;
    end

    // Issue ignores a same-cycle pop, so queued + in-flight never exceeds DEPTH.
    always_comb begin
        issue_ok = 1'b0;
        case (state_q)
            S_IDLE:  issue_ok = (count < CW'(DEPTH));
            S_WAIT:  issue_ok = imem_rvalid &&
                                (({1'b0, count} + (CW + 1)'(1)) < (CW + 1)'(DEPTH));
            S_DROP:  issue_ok = imem_rvalid;
            default: issue_ok = 1'b0;
        endcase
    end

    // ---- next-state logic ------------------------------------------------
    // NOTE: state_next gets a default before any branch so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state_q;
        if (redirect) begin
            if (state_q == S_IDLE) state_next = S_IDLE;
            else if (imem_rvalid)  state_next = S_IDLE;
            else                   state_next = S_DROP;
        end else if (accept) begin
            state_next = S_WAIT;
        end else if (imem_rvalid && state_q != S_IDLE) begin
            state_next = S_IDLE;
        end
    end

    // ---- output logic ------------------------------------------------------
    always_comb begin
        imem_req = Reset_n && !redirect && issue_ok;
        push     = (state_q == S_WAIT) && imem_rvalid && !redirect;
        pop      = if_valid && id_ready && !redirect;
    end

    assign accept    = imem_req && imem_ready;
    assign imem_addr = fetch_pc_q;

    // issue_pc_q tags the outstanding read with the PC it was issued for.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            fetch_pc_q <= RESET_PC;
            issue_pc_q <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
        end else if (accept) begin
            fetch_pc_q <= fetch_pc_q + PC_W'(1);
            issue_pc_q <= fetch_pc_q;
        end
    end

    assign push_entry = '{pc: issue_pc_q, instr: imem_rdata};

    ifq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign if_valid  = (count != '0);
    assign if_instr  = head_entry.instr;
    assign if_pc     = head_entry.pc;
    assign if_opcode = head_entry.instr[OPC_MSB:OPC_LSB];

    // A read cut off by reset may still answer once; that one response is
    // tolerated in S_IDLE, any other response there is a protocol error.
    logic orphan_q;
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            orphan_q <= (orphan_q || state_q != S_IDLE) && !imem_rvalid;
        else if (state_q == S_IDLE && imem_rvalid)
            orphan_q <= 1'b0;
    end

    // Requests leave S_IDLE only by acceptance, so rvalid here would also be a
    // response in the same cycle as its own acceptance.
    a_no_idle_rvalid: assert property (@(posedge Clock) disable iff (!Reset_n)
        !(state_q == S_IDLE && imem_rvalid && !orphan_q));

endmodule
